// File: rtl/fifo_pkg.sv
// Shared defaults and types for the parametrised FIFO slice.
package fifo_pkg;

    localparam int FIFO_WIDTH  = 8;
    localparam int FIFO_ADDR_W = 4;

    typedef logic [FIFO_ADDR_W-1:0] ptr_t;
    typedef logic [FIFO_ADDR_W:0]   cnt_t;

    typedef enum logic {
        RD_REGISTERED = 1'b0,
        RD_FWFT       = 1'b1
    } rd_mode_e;

endpackage

// File: rtl/param_fifo_if.sv
// FIFO client bus: producer/consumer controls on one side, data and status on the other.
interface param_fifo_if
    import fifo_pkg::*;
#(
    parameter int WIDTH  = FIFO_WIDTH,
    parameter int ADDR_W = FIFO_ADDR_W
) ();

    logic              clear;
    logic              wr_en;
    logic [WIDTH-1:0]  wr_data;
    logic              rd_en;
    logic [WIDTH-1:0]  rd_data;
    logic              rd_valid;
    logic              empty;
    logic              full;
    logic              almost_empty;
    logic              almost_full;
    logic [ADDR_W:0]   count;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] wr_addr;
    logic              overflow;
    logic              underflow;

    modport master (
        output clear, wr_en, wr_data, rd_en,
        input  rd_data, rd_valid, empty, full, almost_empty, almost_full,
               count, rd_addr, wr_addr, overflow, underflow
    );

    modport slave (
        input  clear, wr_en, wr_data, rd_en,
        output rd_data, rd_valid, empty, full, almost_empty, almost_full,
               count, rd_addr, wr_addr, overflow, underflow
    );

endinterface

// File: rtl/fifo_ram.sv
// Simple dual-port RAM: one write port, one read port, registered or asynchronous read.
module fifo_ram #(
    parameter int WIDTH   = 8,
    parameter int ADDR_W  = 4,
    parameter int REG_OUT = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    generate
        if (REG_OUT != 0) begin : g_reg
            // Non-blocking read returns the old word when read and write hit the same address.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    rdata <= '0;
                end else if (re) begin
                    rdata <= mem[raddr];
                end
            end
        end else begin : g_async
            logic unused_ctrl;
            assign unused_ctrl = re ^ reset_n;
            assign rdata       = mem[raddr];
        end
    endgenerate

endmodule

// File: rtl/param_fifo.sv
// Circular-queue FIFO: pointers, occupancy count, level flags and sticky error flags.
module param_fifo
    import fifo_pkg::*;
#(
    parameter int WIDTH    = FIFO_WIDTH,
    parameter int ADDR_W   = FIFO_ADDR_W,
    parameter int AF_LEVEL = 14,
    parameter int AE_LEVEL = 2,
    parameter int FWFT     = 0
) (
    input  logic clk,
    input  logic reset_n,
    param_fifo_if.slave bus
);

    localparam rd_mode_e          MODE     = (FWFT != 0) ? RD_FWFT : RD_REGISTERED;
    localparam logic [ADDR_W:0]   DEPTH_C  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   AF_C     = (ADDR_W+1)'(AF_LEVEL);
    localparam logic [ADDR_W:0]   AE_C     = (ADDR_W+1)'(AE_LEVEL);
    localparam logic [ADDR_W:0]   CNT_STEP = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_STEP = ADDR_W'(1);

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   cnt;
    logic              empty_i;
    logic              full_i;
    logic              wr_acc;
    logic              rd_acc;
    logic              rd_valid_q;
    logic              ovf_q;
    logic              udf_q;
    logic [WIDTH-1:0]  ram_q;

    // clear masks both requests, so it also suppresses error flagging that cycle.
    always_comb begin
        empty_i = (cnt == '0);
        full_i  = (cnt == DEPTH_C);
        rd_acc  = bus.rd_en & ~empty_i & ~bus.clear;
        wr_acc  = bus.wr_en & (~full_i | rd_acc) & ~bus.clear;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (bus.clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + PTR_STEP;
            if (rd_acc) rd_ptr <= rd_ptr + PTR_STEP;
            case ({wr_acc, rd_acc})
                2'b10:   cnt <= cnt + CNT_STEP;
                2'b01:   cnt <= cnt - CNT_STEP;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
        end else begin
            rd_valid_q <= rd_acc;
            ovf_q      <= ovf_q | (bus.wr_en & full_i & ~rd_acc & ~bus.clear);
            udf_q      <= udf_q | (bus.rd_en & empty_i & ~bus.clear);
        end
    end

    fifo_ram #(
        .WIDTH   (WIDTH),
        .ADDR_W  (ADDR_W),
        .REG_OUT ((MODE == RD_REGISTERED) ? 1 : 0)
    ) u_ram (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (wr_acc),
        .waddr   (wr_ptr),
        .wdata   (bus.wr_data),
        .re      (rd_acc),
        .raddr   (rd_ptr),
        .rdata   (ram_q)
    );

    assign bus.rd_data      = ram_q;
    assign bus.rd_valid     = (MODE == RD_FWFT) ? ~empty_i : rd_valid_q;
    assign bus.empty        = empty_i;
    assign bus.full         = full_i;
    assign bus.almost_empty = (cnt <= AE_C);
    assign bus.almost_full  = (cnt >= AF_C);
    assign bus.count        = cnt;
    assign bus.rd_addr      = rd_ptr;
    assign bus.wr_addr      = wr_ptr;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = udf_q;

endmodule

// File: tb/tb_param_fifo.sv
// Scoreboard bench for param_fifo in registered-read (dut0) and FWFT (dut1) modes.
module tb_param_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n0;
    logic reset_n1;
    int   errors = 0;
    int   checks = 0;
    logic [7:0] sb[$];
    logic [7:0] exp_d;

    param_fifo_if #(.WIDTH(8), .ADDR_W(4)) bus0 ();
    param_fifo_if #(.WIDTH(8), .ADDR_W(4)) bus1 ();

    param_fifo #(.WIDTH(8), .ADDR_W(4), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(0)) dut0 (
        .clk(clk), .reset_n(reset_n0), .bus(bus0)
    );

    param_fifo #(.WIDTH(8), .ADDR_W(4), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(1)) dut1 (
        .clk(clk), .reset_n(reset_n1), .bus(bus1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus0.clear = 1'b0; bus0.wr_en = 1'b0; bus0.rd_en = 1'b0; bus0.wr_data = '0;
        bus1.clear = 1'b0; bus1.wr_en = 1'b0; bus1.rd_en = 1'b0; bus1.wr_data = '0;
    endtask

    task automatic reset0();
        reset_n0 = 1'b0;
        step();
        reset_n0 = 1'b1;
        step();
        sb.delete();
    endtask

    task automatic fill0(input logic [7:0] base, input int n);
        for (int i = 1; i <= n; i++) begin
            bus0.wr_en   = 1'b1;
            bus0.wr_data = base + 8'(i);
            sb.push_back(base + 8'(i));
            step();
        end
        bus0.wr_en = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset_n0 = 1'b0;
        reset_n1 = 1'b0;
        step();
        step();
        reset_n0 = 1'b1;
        reset_n1 = 1'b1;
        step();
        checks++;
        if ({bus0.empty, bus0.almost_empty, bus0.full, bus0.almost_full,
             bus0.rd_valid, bus0.overflow, bus0.underflow} !== 7'b1100000) begin
            errors++;
            $display("FAIL reset_flags: got e/ae/f/af/v/ov/un=%b expected 1100000",
                     {bus0.empty, bus0.almost_empty, bus0.full, bus0.almost_full,
                      bus0.rd_valid, bus0.overflow, bus0.underflow});
        end
        checks++;
        if (bus0.count !== 5'd0 || bus0.rd_data !== 8'h00 || bus0.wr_addr !== 4'd0 || bus0.rd_addr !== 4'd0) begin
            errors++;
            $display("FAIL reset_regs: got count=%0d rd_data=%0h wa=%0d ra=%0d expected all 0",
                     bus0.count, bus0.rd_data, bus0.wr_addr, bus0.rd_addr);
        end
        checks++;
        if (bus1.empty !== 1'b1 || bus1.rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_fwft: got empty=%b rd_valid=%b expected 1 0", bus1.empty, bus1.rd_valid);
        end
    endtask

    task automatic test_fill_drain();
        sb.delete();
        for (int i = 1; i <= 16; i++) begin
            bus0.wr_en   = 1'b1;
            bus0.wr_data = 8'(i);
            sb.push_back(8'(i));
            step();
            checks++;
            if (bus0.count !== 5'(i) || bus0.full !== (i == 16) || bus0.almost_full !== (i >= 14)) begin
                errors++;
                $display("FAIL fill_flags[%0d]: got count=%0d full=%b af=%b expected %0d %b %b",
                         i, bus0.count, bus0.full, bus0.almost_full, i, (i == 16), (i >= 14));
            end
        end
        bus0.wr_en = 1'b0;
        bus0.rd_en = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            step();
            exp_d = sb.pop_front();
            checks++;
            if (bus0.rd_valid !== 1'b1 || bus0.rd_data !== exp_d) begin
                errors++;
                $display("FAIL drain_data[%0d]: got valid=%b data=%0h expected 1 %0h",
                         i, bus0.rd_valid, bus0.rd_data, exp_d);
            end
            checks++;
            if (bus0.count !== 5'(16 - i) || bus0.almost_empty !== ((16 - i) <= 2)) begin
                errors++;
                $display("FAIL drain_flags[%0d]: got count=%0d ae=%b expected %0d %b",
                         i, bus0.count, bus0.almost_empty, 16 - i, ((16 - i) <= 2));
            end
        end
        bus0.rd_en = 1'b0;
        step();
        checks++;
        if (bus0.rd_valid !== 1'b0 || bus0.empty !== 1'b1 || bus0.rd_data !== 8'h10) begin
            errors++;
            $display("FAIL drain_end: got valid=%b empty=%b data=%0h expected 0 1 10",
                     bus0.rd_valid, bus0.empty, bus0.rd_data);
        end
    endtask

    task automatic test_errors();
        logic [3:0] ra_before;
        sb.delete();
        fill0(8'h20, 16);
        bus0.wr_en   = 1'b1;
        bus0.wr_data = 8'hAA;
        step();
        bus0.wr_en = 1'b0;
        checks++;
        if (bus0.overflow !== 1'b1 || bus0.underflow !== 1'b0 || bus0.count !== 5'd16) begin
            errors++;
            $display("FAIL overflow: got ov=%b un=%b count=%0d expected 1 0 16",
                     bus0.overflow, bus0.underflow, bus0.count);
        end
        bus0.rd_en = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            step();
            exp_d = sb.pop_front();
            checks++;
            if (bus0.rd_valid !== 1'b1 || bus0.rd_data !== exp_d) begin
                errors++;
                $display("FAIL ovf_drain[%0d]: got valid=%b data=%0h expected 1 %0h",
                         i, bus0.rd_valid, bus0.rd_data, exp_d);
            end
        end
        bus0.rd_en = 1'b0;
        step();
        ra_before  = bus0.rd_addr;
        bus0.rd_en = 1'b1;
        step();
        bus0.rd_en = 1'b0;
        checks++;
        if (bus0.underflow !== 1'b1 || bus0.rd_valid !== 1'b0 || bus0.count !== 5'd0 || bus0.rd_addr !== ra_before) begin
            errors++;
            $display("FAIL underflow: got un=%b valid=%b count=%0d ra=%0d expected 1 0 0 %0d",
                     bus0.underflow, bus0.rd_valid, bus0.count, bus0.rd_addr, ra_before);
        end
        bus0.clear = 1'b1;
        step();
        bus0.clear = 1'b0;
        checks++;
        if (bus0.overflow !== 1'b1 || bus0.underflow !== 1'b1) begin
            errors++;
            $display("FAIL sticky_clear: got ov=%b un=%b expected 1 1", bus0.overflow, bus0.underflow);
        end
        reset0();
        checks++;
        if (bus0.overflow !== 1'b0 || bus0.underflow !== 1'b0) begin
            errors++;
            $display("FAIL sticky_reset: got ov=%b un=%b expected 0 0", bus0.overflow, bus0.underflow);
        end
    endtask

    task automatic test_clear();
        reset0();
        for (int i = 1; i <= 3; i++) begin
            bus0.wr_en   = 1'b1;
            bus0.wr_data = 8'h30 + 8'(i);
            step();
        end
        bus0.clear   = 1'b1;
        bus0.wr_en   = 1'b1;
        bus0.rd_en   = 1'b1;
        bus0.wr_data = 8'h44;
        step();
        idle_inputs();
        checks++;
        if (bus0.count !== 5'd0 || bus0.empty !== 1'b1 || bus0.wr_addr !== 4'd0 ||
            bus0.rd_addr !== 4'd0 || bus0.rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL clear_state: got count=%0d empty=%b wa=%0d ra=%0d valid=%b expected 0 1 0 0 0",
                     bus0.count, bus0.empty, bus0.wr_addr, bus0.rd_addr, bus0.rd_valid);
        end
        fill0(8'h54, 1);
        bus0.rd_en = 1'b1;
        step();
        bus0.rd_en = 1'b0;
        exp_d = sb.pop_front();
        checks++;
        if (bus0.rd_valid !== 1'b1 || bus0.rd_data !== exp_d) begin
            errors++;
            $display("FAIL clear_after: got valid=%b data=%0h expected 1 %0h", bus0.rd_valid, bus0.rd_data, exp_d);
        end
    endtask

    task automatic test_wrap();
        reset0();
        for (int pass = 0; pass < 2; pass++) begin
            fill0(8'h80 + 8'(pass * 16), 10);
            if (pass == 1) begin
                checks++;
                if (bus0.wr_addr !== 4'h4 || bus0.rd_addr !== 4'hA || bus0.count !== 5'd10) begin
                    errors++;
                    $display("FAIL wrap_ptrs: got wa=%0h ra=%0h count=%0d expected 4 a 10",
                             bus0.wr_addr, bus0.rd_addr, bus0.count);
                end
            end
            bus0.rd_en = 1'b1;
            for (int i = 1; i <= 10; i++) begin
                step();
                exp_d = sb.pop_front();
                checks++;
                if (bus0.rd_valid !== 1'b1 || bus0.rd_data !== exp_d) begin
                    errors++;
                    $display("FAIL wrap_data[%0d.%0d]: got valid=%b data=%0h expected 1 %0h",
                             pass, i, bus0.rd_valid, bus0.rd_data, exp_d);
                end
            end
            bus0.rd_en = 1'b0;
        end
    endtask

    task automatic test_simultaneous();
        reset0();
        fill0(8'hC0, 16);
        bus0.wr_en = 1'b1;
        bus0.rd_en = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            bus0.wr_data = 8'hE0 + 8'(k);
            exp_d = sb.pop_front();
            sb.push_back(8'hE0 + 8'(k));
            step();
            checks++;
            if (bus0.count !== 5'd16 || bus0.full !== 1'b1 || bus0.rd_valid !== 1'b1 ||
                bus0.rd_data !== exp_d || bus0.overflow !== 1'b0) begin
                errors++;
                $display("FAIL simul_full[%0d]: got count=%0d full=%b valid=%b data=%0h ov=%b expected 16 1 1 %0h 0",
                         k, bus0.count, bus0.full, bus0.rd_valid, bus0.rd_data, bus0.overflow, exp_d);
            end
        end
        bus0.wr_en = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            step();
            exp_d = sb.pop_front();
            checks++;
            if (bus0.rd_valid !== 1'b1 || bus0.rd_data !== exp_d) begin
                errors++;
                $display("FAIL simul_drain[%0d]: got valid=%b data=%0h expected 1 %0h",
                         i, bus0.rd_valid, bus0.rd_data, exp_d);
            end
        end
        bus0.rd_en = 1'b0;
        step();
        bus0.wr_en   = 1'b1;
        bus0.rd_en   = 1'b1;
        bus0.wr_data = 8'h99;
        sb.push_back(8'h99);
        step();
        bus0.wr_en = 1'b0;
        bus0.rd_en = 1'b0;
        checks++;
        if (bus0.count !== 5'd1 || bus0.underflow !== 1'b1 || bus0.rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL simul_empty: got count=%0d un=%b valid=%b expected 1 1 0",
                     bus0.count, bus0.underflow, bus0.rd_valid);
        end
        bus0.rd_en = 1'b1;
        step();
        bus0.rd_en = 1'b0;
        exp_d = sb.pop_front();
        checks++;
        if (bus0.rd_valid !== 1'b1 || bus0.rd_data !== exp_d) begin
            errors++;
            $display("FAIL simul_empty_data: got valid=%b data=%0h expected 1 %0h", bus0.rd_valid, bus0.rd_data, exp_d);
        end
    endtask

    task automatic test_fwft();
        sb.delete();
        bus1.wr_en   = 1'b1;
        bus1.wr_data = 8'h5A;
        sb.push_back(8'h5A);
        step();
        bus1.wr_en = 1'b0;
        exp_d = sb.pop_front();
        checks++;
        if (bus1.rd_valid !== 1'b1 || bus1.rd_data !== exp_d || bus1.count !== 5'd1) begin
            errors++;
            $display("FAIL fwft_first: got valid=%b data=%0h count=%0d expected 1 %0h 1",
                     bus1.rd_valid, bus1.rd_data, bus1.count, exp_d);
        end
        bus1.rd_en = 1'b1;
        step();
        bus1.rd_en = 1'b0;
        checks++;
        if (bus1.rd_valid !== 1'b0 || bus1.empty !== 1'b1) begin
            errors++;
            $display("FAIL fwft_pop: got valid=%b empty=%b expected 0 1", bus1.rd_valid, bus1.empty);
        end
        for (int i = 1; i <= 8; i++) begin
            bus1.wr_en   = 1'b1;
            bus1.wr_data = 8'h60 + 8'(i);
            sb.push_back(8'h60 + 8'(i));
            step();
        end
        bus1.wr_en = 1'b0;
        for (int i = 1; i <= 2; i++) begin
            checks++;
            if (bus1.rd_data !== sb[0]) begin
                errors++;
                $display("FAIL fwft_head[%0d]: got data=%0h expected %0h", i, bus1.rd_data, sb[0]);
            end
            if (i == 1) begin
                void'(sb.pop_front());
                bus1.rd_en = 1'b1;
                step();
                bus1.rd_en = 1'b0;
            end
        end
        checks++;
        if (bus1.count !== 5'd7 || bus1.rd_valid !== 1'b1) begin
            errors++;
            $display("FAIL fwft_count: got count=%0d valid=%b expected 7 1", bus1.count, bus1.rd_valid);
        end
        #2;
        reset_n1 = 1'b0;
        #1;
        checks++;
        if (bus1.count !== 5'd0 || bus1.empty !== 1'b1 || bus1.rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL fwft_async_reset: got count=%0d empty=%b valid=%b expected 0 1 0",
                     bus1.count, bus1.empty, bus1.rd_valid);
        end
        reset_n1 = 1'b1;
        step();
        sb.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n0 = 1'b1;
        reset_n1 = 1'b1;
        test_reset();
        test_fill_drain();
        test_errors();
        test_clear();
        test_wrap();
        test_simultaneous();
        test_fwft();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
